// File: rtl/basic_add16.sv
// ============================================================================
// basic_add16 : registered 16-bit ripple-carry adder built from half-adder cells.
// Optional macro ADD16_OVF_EN adds the registered two's-complement overflow output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module GateLevelHalfAdder (
  input  logic a,
  input  logic b,
  output logic h,
  output logic l
);
  assign h = a & b;
  assign l = a ^ b;
endmodule

module basic_add16_fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  logic w_p;
  logic w_g;
  logic w_t;

  GateLevelHalfAdder u_ha_ab (.a(a),   .b(b), .h(w_g), .l(w_p));
  GateLevelHalfAdder u_ha_pc (.a(w_p), .b(c), .h(w_t), .l(s));

  assign co = w_g | w_t;
endmodule

module basic_add16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic        out_valid,
  output logic [15:0] sum,
`ifdef ADD16_OVF_EN
  output logic        ovf,
`endif
  output logic        cout
);
  logic [16:0] w_carry;
  logic [15:0] w_sum;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < 16; i++) begin : g_bit
    basic_add16_fa u_fa (
      .a (a[i]),
      .b (b[i]),
      .c (w_carry[i]),
      .s (w_sum[i]),
      .co(w_carry[i+1])
    );
  end

  logic        out_valid_q;
  logic [15:0] sum_q;
  logic [15:0] sum_d;
  logic        cout_q;
  logic        cout_d;

  // Result registers hold while idle; only out_valid drops back to zero.
  assign sum_d  = in_valid ? w_sum       : sum_q;
  assign cout_d = in_valid ? w_carry[16] : cout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= 16'h0000;
      cout_q      <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

`ifdef ADD16_OVF_EN
  logic ovf_q;
  logic ovf_d;

  assign ovf_d = in_valid ? (w_carry[15] ^ w_carry[16]) : ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_basic_add16.sv
// Table-driven bench for basic_add16: streaming vectors, hold, and async reset sequences.
`default_nettype none

module tb_basic_add16;
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic [15:0] sum;
  logic        cout;
`ifdef ADD16_OVF_EN
  logic        ovf;
`endif

  int total = 0;
  int bad   = 0;

  basic_add16 dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .sum      (sum),
`ifdef ADD16_OVF_EN
    .ovf      (ovf),
`endif
    .cout     (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic v, input logic [15:0] s,
                         input logic c, input logic o);
    chk({name, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({name, ".sum"},   {16'd0, sum},       {16'd0, s});
    chk({name, ".cout"},  {31'd0, cout},      {31'd0, c});
`ifdef ADD16_OVF_EN
    chk({name, ".ovf"},   {31'd0, ovf},       {31'd0, o});
`else
    if (o === 1'bx) $display("unexpected x flag in %s", name);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // a, b, cin -> sum, cout, ovf (hand computed)
    vecs[0]  = '{16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
    vecs[3]  = '{16'h0001, 16'h0000, 1'b1, 16'h0002, 1'b0, 1'b0};
    vecs[4]  = '{16'h8000, 16'h0000, 1'b1, 16'h8001, 1'b0, 1'b0};
    vecs[5]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[6]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[8]  = '{16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vecs[9]  = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[10] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[11] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick();
    tick();
    chk_out("reset", 1'b0, 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;
    tick();

    // Back-to-back stream: each result checked one edge after its operands.
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin;
      tick();
      chk_out($sformatf("vec%0d", i), 1'b1, vecs[i].sum, vecs[i].cout, vecs[i].ovf);
    end

    // Hold: idle inputs must not disturb the last result.
    in_valid = 1'b0; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    tick();
    chk_out("hold1", 1'b0, 16'h1000, 1'b0, 1'b0);
    tick();
    chk_out("hold2", 1'b0, 16'h1000, 1'b0, 1'b0);

    // Async reset mid-cycle after a result with cout/ovf set.
    in_valid = 1'b1; a = 16'h8000; b = 16'h8000; cin = 1'b0;
    tick();
    chk_out("pre_rst", 1'b1, 16'h0000, 1'b1, 1'b1);
    a = 16'h7FFF; b = 16'h0000; cin = 1'b1;
    tick();
    chk_out("pre_rst2", 1'b1, 16'h8000, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 1'b0, 16'h0000, 1'b0, 1'b0);

    // in_valid high while reset is held across an edge: no result.
    tick();
    chk_out("rst_wins", 1'b0, 16'h0000, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    a = 16'hFFFF; b = 16'h0000; cin = 1'b1;
    tick();
    chk_out("post_rst", 1'b1, 16'h0000, 1'b1, 1'b0);
    in_valid = 1'b0;
    tick();
    chk_out("post_idle", 1'b0, 16'h0000, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/basic_add16.md
# basic_add16

16-bit ripple-carry adder with carry-in and carry-out, built structurally from gate-level half-adder cells. Results are registered, so the block delivers one sum per accepted operand pair, one cycle after acceptance. It is the arithmetic core under the increment units: with b = 0 and cin = 1 it computes in + 1. It also serves as a general adder for the ALU datapath.

## Interface
- Parameters: none; width is fixed at 16.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands are valid this cycle; capture the result.
- a  input  16  addend A.
- b  input  16  addend B.
- cin  input  1  carry into bit 0.
- out_valid  output  1  registered; high for one cycle per accepted operand set.
- sum  output  16  registered (a + b + cin) mod 2^16.
- cout  output  1  registered carry out of bit 15.
- ovf  output  1  registered two's-complement overflow. Present only with ADD16_OVF_EN.

## Operation
- Half-adder cell (GateLevelHalfAdder): inputs a, b; outputs h = a AND b (carry) and l = a XOR b (sum bit).
- Full-adder cell: two half adders plus one OR.
  - Cell 1: HA(a_i, b_i) gives p_i = l1 and g_i = h1.
  - Cell 2: HA(p_i, c_i) gives s_i = l2 and t_i = h2.
  - c_{i+1} = g_i OR t_i.
- Chain: c_0 = cin. Bits 0..15 ripple. cout = c_16.
- No behavioural "+" operator is used in the core. The structure must remain 16 full-adder cells, 32 half-adder instances in total.
- Overflow: ovf = c_15 XOR c_16. This is equivalent to both operands sharing a sign that differs from the sign of the sum.
- Register stage:
  - When in_valid = 1 at a rising edge: sum, cout and ovf load the combinational results, and out_valid <= 1.
  - When in_valid = 0 at a rising edge: sum, cout and ovf hold their previous values, and out_valid <= 0.
- Back-to-back operation: operands may arrive every cycle. Each produces its own result, with no bubbles and no backpressure.
- Arithmetic is unsigned modulo 2^16. cout is the 17th bit. Wrap-around is not an error: 0xFFFF + 0 + 1 gives sum 0x0000, cout 1.

## Timing
- Latency: exactly 1 clock from the in_valid sample to out_valid and the result appearing.
- Throughput: 1 result per clock.
- Reset:
  - Asserting rst clears sum = 0x0000, cout = 0, ovf = 0 and out_valid = 0 immediately, without waiting for a clock edge.
  - A result in flight when reset asserts is discarded.
  - The first edge after rst deasserts with in_valid = 1 produces a normal result one cycle later.
- in_valid high on the same edge where rst is asserted: reset wins, and no result is produced.
- The combinational ripple path (cin to cout through 16 cells) must close within one clock period. No internal pipelining.

## Configuration
- ADD16_OVF_EN
  - Defined: the ovf port exists, along with its register and its reset behaviour as above.
  - Undefined: the ovf port, its register and its XOR are absent. All other behaviour is identical.

## Test plan
- Increment: a = 0x00FF, b = 0x0000, cin = 1, in_valid = 1 -> next cycle sum = 0x0100, cout = 0, out_valid = 1.
- Wrap: a = 0xFFFF, b = 0, cin = 1 -> sum = 0x0000, cout = 1, ovf = 0.
- Signed overflow: a = 0x7FFF, b = 0, cin = 1 -> sum = 0x8000, cout = 0, ovf = 1 (ADD16_OVF_EN defined).
- Streaming: back-to-back 0x0001+0+1, then 0x8000+0+1, then 0x1234+0x4321+0 -> sums 0x0002, 0x8001, 0x5555 on consecutive cycles, out_valid held high.
- Hold: in_valid = 0 after a result -> sum and cout unchanged, out_valid = 0 for the following cycles.
- Async reset: assert rst mid-stream between clock edges -> sum, cout, ovf and out_valid read 0 immediately. Next valid input after release produces the correct result one cycle later.
